fabric_bitstream_loader: RTL and testbench

Configuration controller for the FPGA fabric. It receives a 32-bit word-serial bitstream with a valid qualifier and assembles one frame of FrameBitsPerRow x NumRows bits. It then pulses exactly one frame strobe, addressed by column and frame index, into the fabric's configuration latches. It sits between the bitstream source (SPI, UART or CPU) and the fabric wrapper's FrameData/FrameStrobe inputs. It flags configuration in progress so the fabric's user logic (e.g. the warmboot reset) is held off.

---
 rtl/fabric_bitstream_loader_pkg.sv | 22 ++
 rtl/fabric_bitstream_loader_if.sv | 12 +
 rtl/fabric_frame_strobe_decoder.sv | 27 ++
 rtl/fabric_bitstream_loader.sv | 125 ++++++++++++
 tb/tb_fabric_bitstream_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fabric_bitstream_loader_pkg.sv
// Shared constants and types for the fabric bitstream loader: session
// control words, header field positions and the loader state encoding.
package fabric_bitstream_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [WORD_W-1:0] DESYNC_WORD = 32'hFAB0_FAB0;

  // Header word layout: column and frame index of the frame that follows.
  localparam int COL_MSB   = 15;
  localparam int COL_LSB   = 8;
  localparam int FRAME_MSB = 7;
  localparam int FRAME_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_e;

endpackage

// File: rtl/fabric_bitstream_loader_if.sv
// Word-serial bitstream channel: one 32-bit word per cycle when valid is
// high, with no backpressure towards the source.
interface fabric_bitstream_loader_if;
  import fabric_bitstream_pkg::*;

  logic [WORD_W-1:0] data;
  logic              valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);

endinterface

// File: rtl/fabric_frame_strobe_decoder.sv
// Combinational decode of (column, frame, fire) into the one-hot frame
// strobe vector. Indices outside the fabric produce an all-zero vector.
module fabric_frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 12
) (
  input  logic [7:0]                              col,
  input  logic [7:0]                              frame,
  input  logic                                    fire,
  output logic [MaxFramesPerCol*NumColumns-1:0]   strobe
);

  localparam int StrobeW = MaxFramesPerCol * NumColumns;

  logic        in_range_s;
  logic [15:0] idx_s;

  // Range-check the address and raise the single addressed strobe bit.
  always_comb begin
    in_range_s = (16'(col) < 16'(NumColumns)) && (16'(frame) < 16'(MaxFramesPerCol));
    idx_s      = (16'(col) * 16'(MaxFramesPerCol)) + 16'(frame);
    for (int i = 0; i < StrobeW; i++) begin
      strobe[i] = fire & in_range_s & (idx_s == 16'(i));
    end
  end

endmodule

// File: rtl/fabric_bitstream_loader.sv
// Configuration controller: waits for SYNC, then decodes a header
// (column/frame) followed by NumRows data words written straight into the
// frame data register, and finally pulses one registered frame strobe.
// DESYNC in place of a header closes the session.
module fabric_bitstream_loader
  import fabric_bitstream_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 12,
  parameter int NumRows         = 18
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  fabric_bitstream_loader_if.slave               bs_if,
  output logic                                   busy_o,
  output logic [FrameBitsPerRow*NumRows-1:0]     FrameData_o,
  output logic [MaxFramesPerCol*NumColumns-1:0]  FrameStrobe_o
);

  localparam int FrameW  = FrameBitsPerRow * NumRows;
  localparam int StrobeW = MaxFramesPerCol * NumColumns;
  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  state_e              state_r, state_next_s;
  logic [RowW-1:0]     row_r, row_next_s;
  logic [7:0]          col_r, col_next_s;
  logic [7:0]          frame_r, frame_next_s;
  logic [FrameW-1:0]   frame_data_r, frame_data_next_s;
  logic [StrobeW-1:0]  strobe_r, strobe_s;
  logic                busy_r;
  logic                fire_s;

  // Next-state, header latch and row write decode for one accepted word.
  always_comb begin
    state_next_s      = state_r;
    row_next_s        = row_r;
    col_next_s        = col_r;
    frame_next_s      = frame_r;
    frame_data_next_s = frame_data_r;
    fire_s            = 1'b0;
    if (bs_if.valid) begin
      case (state_r)
        IDLE: begin
          if (bs_if.data == SYNC_WORD) begin
            state_next_s = HEADER;
          end else begin
            state_next_s = IDLE;
          end
        end
        HEADER: begin
          // DESYNC wins over header decode.
          if (bs_if.data == DESYNC_WORD) begin
            state_next_s = IDLE;
          end else begin
            col_next_s   = bs_if.data[COL_MSB:COL_LSB];
            frame_next_s = bs_if.data[FRAME_MSB:FRAME_LSB];
            row_next_s   = '0;
            state_next_s = DATA;
          end
        end
        DATA: begin
          for (int r = 0; r < NumRows; r++) begin
            if (row_r == RowW'(r)) begin
              frame_data_next_s[r*FrameBitsPerRow +: FrameBitsPerRow] = bs_if.data;
            end else begin
              frame_data_next_s[r*FrameBitsPerRow +: FrameBitsPerRow] =
                frame_data_r[r*FrameBitsPerRow +: FrameBitsPerRow];
            end
          end
          if (row_r == LastRow) begin
            fire_s       = 1'b1;
            row_next_s   = '0;
            state_next_s = HEADER;
          end else begin
            row_next_s   = row_r + RowW'(1);
            state_next_s = DATA;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  fabric_frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumColumns      (NumColumns)
  ) u_strobe_dec (
    .col    (col_r),
    .frame  (frame_r),
    .fire   (fire_s),
    .strobe (strobe_s)
  );

  // State, header fields, frame data and the registered strobe/busy outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      row_r        <= '0;
      col_r        <= 8'd0;
      frame_r      <= 8'd0;
      frame_data_r <= '0;
      strobe_r     <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      row_r        <= row_next_s;
      col_r        <= col_next_s;
      frame_r      <= frame_next_s;
      frame_data_r <= frame_data_next_s;
      strobe_r     <= strobe_s;
      busy_r       <= (state_next_s != IDLE);
    end
  end

  assign busy_o        = busy_r;
  assign FrameData_o   = frame_data_r;
  assign FrameStrobe_o = strobe_r;

endmodule

// File: tb/tb_fabric_bitstream_loader.sv
// Randomised bench for fabric_bitstream_loader with a session-level
// reference model of the bitstream protocol.
module tb_fabric_bitstream_loader;

  localparam int W     = 32;
  localparam int NR    = 18;
  localparam int MF    = 20;
  localparam int NC    = 12;
  localparam int FD_W  = W * NR;
  localparam int FS_W  = MF * NC;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy_o;
  logic [FD_W-1:0]   FrameData_o;
  logic [FS_W-1:0]   FrameStrobe_o;

  fabric_bitstream_loader_if bs_if ();

  fabric_bitstream_loader dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bs_if         (bs_if),
    .busy_o        (busy_o),
    .FrameData_o   (FrameData_o),
    .FrameStrobe_o (FrameStrobe_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: session open flag, words still owed to the frame,
  // the current frame's address and the expected outputs.
  bit              m_session;
  int              m_words_left;  // 0 means the next word is a header
  int              m_col;
  int              m_frame;
  bit              m_busy;
  logic [FD_W-1:0] m_data;
  int              m_strobe_idx;  // -1 when no strobe is expected

  int              pulse_cnt;
  int              last_idx;
  logic [31:0]     rows_q [NR];

  task automatic check_val(input string tag, input logic [FD_W-1:0] obs, input logic [FD_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic r);
    if (r) begin
      m_session = 1'b0; m_words_left = 0; m_busy = 1'b0;
      m_data = '0; m_strobe_idx = -1;
    end else begin
      m_strobe_idx = -1;
      if (v) begin
        if (!m_session) begin
          if (d == SYNC) begin
            m_session = 1'b1; m_words_left = 0;
          end
        end else if (m_words_left == 0) begin
          if (d == DESYNC) begin
            m_session = 1'b0;
          end else begin
            m_col = int'(d[15:8]); m_frame = int'(d[7:0]); m_words_left = NR;
          end
        end else begin
          m_data[(NR - m_words_left)*W +: W] = d;
          m_words_left--;
          if (m_words_left == 0 && m_col < NC && m_frame < MF)
            m_strobe_idx = m_col * MF + m_frame;
        end
      end
      m_busy = m_session;
    end
  endtask

  task automatic compare_all();
    logic [FS_W-1:0] exp_s;
    exp_s = '0;
    if (m_strobe_idx >= 0) exp_s[m_strobe_idx] = 1'b1;
    check_val("busy", FD_W'(busy_o), FD_W'(m_busy));
    check_val("strobe", FD_W'(FrameStrobe_o), FD_W'(exp_s));
    check_val("frame_data", FrameData_o, m_data);
    if (FrameStrobe_o != '0) begin
      pulse_cnt++;
      for (int i = 0; i < FS_W; i++) if (FrameStrobe_o[i]) last_idx = i;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic r);
    rst = r; bs_if.valid = v; bs_if.data = d;
    @(posedge clk);
    model_edge(v, d, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_gaps(input int max_gap);
    int n;
    n = $urandom_range(max_gap, 0);
    repeat (n) step(1'b0, $urandom, 1'b0);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input int max_gap);
    step(1'b1, hdr, 1'b0);
    for (int r = 0; r < NR; r++) begin
      idle_gaps(max_gap);
      step(1'b1, rows_q[r], 1'b0);
    end
  endtask

  function automatic logic [31:0] non_sync();
    logic [31:0] x;
    x = $urandom;
    if (x == SYNC) x = x ^ 32'd1;
    return x;
  endfunction

  function automatic logic [FD_W-1:0] rows_vec();
    logic [FD_W-1:0] v;
    for (int r = 0; r < NR; r++) v[r*W +: W] = rows_q[r];
    return v;
  endfunction

  logic [31:0] r32;
  logic [FD_W-1:0] hold_data;

  initial begin
    rst = 1'b1; bs_if.valid = 1'b1; bs_if.data = SYNC;
    m_col = 0; m_frame = 0; pulse_cnt = 0; last_idx = -1;

    // Reset held with SYNC on the bus.
    step(1'b1, SYNC, 1'b1);
    step(1'b1, SYNC, 1'b1);

    // Header-format and other words before SYNC are ignored.
    step(1'b1, 32'h0000_0305, 1'b0);
    for (int i = 0; i < 5; i++) step(1'($urandom_range(1, 0)), non_sync(), 1'b0);
    check_val("pre_sync_busy", FD_W'(busy_o), FD_W'(1'b0));

    // Single frame, col 3 frame 5.
    for (int r = 0; r < NR; r++) rows_q[r] = 32'h1000_0000 + 32'(r);
    step(1'b1, SYNC, 1'b0);
    pulse_cnt = 0; last_idx = -1;
    send_frame(32'h0000_0305, 0);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check_val("single_pulses", FD_W'(pulse_cnt), FD_W'(1));
    check_val("single_idx", FD_W'(last_idx), FD_W'(65));
    check_val("single_rows", FrameData_o, rows_vec());
    check_val("single_busy", FD_W'(busy_o), FD_W'(1'b1));

    // Same frame with random idle gaps.
    pulse_cnt = 0; last_idx = -1;
    send_frame(32'h0000_0305, 3);
    idle_gaps(3);
    step(1'b0, 32'd0, 1'b0);
    check_val("gap_pulses", FD_W'(pulse_cnt), FD_W'(1));
    check_val("gap_idx", FD_W'(last_idx), FD_W'(65));
    check_val("gap_rows", FrameData_o, rows_vec());

    // Out-of-range column, then out-of-range frame: no strobe.
    pulse_cnt = 0; last_idx = -1;
    for (int r = 0; r < NR; r++) rows_q[r] = $urandom;
    r32 = $urandom;
    send_frame({r32[31:16], 8'd12, 8'd0}, 1);
    for (int r = 0; r < NR; r++) rows_q[r] = $urandom;
    send_frame(32'h0000_0014, 1);
    step(1'b0, 32'd0, 1'b0);
    check_val("oor_pulses", FD_W'(pulse_cnt), FD_W'(0));
    check_val("oor_rows", FrameData_o, rows_vec());
    for (int r = 0; r < NR; r++) rows_q[r] = $urandom;
    send_frame(32'h0000_0B13, 1);
    step(1'b0, 32'd0, 1'b0);
    check_val("last_pulses", FD_W'(pulse_cnt), FD_W'(1));
    check_val("last_idx", FD_W'(last_idx), FD_W'(239));

    // DESYNC closes the session and keeps the frame data.
    hold_data = rows_vec();
    step(1'b1, DESYNC, 1'b0);
    check_val("desync_busy", FD_W'(busy_o), FD_W'(1'b0));
    check_val("desync_data", FrameData_o, hold_data);
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'($urandom_range(1, 0)), non_sync(), 1'b0);
    check_val("post_desync_busy", FD_W'(busy_o), FD_W'(1'b0));
    check_val("post_desync_data", FrameData_o, hold_data);
    check_val("post_desync_pulses", FD_W'(pulse_cnt), FD_W'(0));

    // Reset after 7 data words, then a full frame to col 0 frame 0.
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 32'h0000_0102, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0);
    pulse_cnt = 0; last_idx = -1;
    step(1'b1, $urandom, 1'b1);
    check_val("mid_reset_data", FrameData_o, {FD_W{1'b0}});
    for (int r = 0; r < NR; r++) rows_q[r] = $urandom;
    step(1'b1, SYNC, 1'b0);
    send_frame(32'h0000_0000, 1);
    step(1'b0, 32'd0, 1'b0);
    check_val("reset_frame_pulses", FD_W'(pulse_cnt), FD_W'(1));
    check_val("reset_frame_idx", FD_W'(last_idx), FD_W'(0));
    check_val("reset_frame_rows", FrameData_o, rows_vec());

    // Random sessions: frames with random addresses, gaps and desyncs.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(5, 0) == 0) begin
        step(1'b1, DESYNC, 1'b0);
        for (int i = 0; i < 3; i++) step(1'($urandom_range(1, 0)), non_sync(), 1'b0);
        step(1'b1, SYNC, 1'b0);
      end else begin
        for (int r = 0; r < NR; r++) rows_q[r] = $urandom;
        r32 = $urandom;
        send_frame({r32[31:16], 8'($urandom_range(13, 0)), 8'($urandom_range(21, 0))}, 2);
        idle_gaps(1);
      end
    end
    step(1'b0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
